codec_cfg_seq: RTL
==================

CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Purpose: sequences the audio codec register writes over a byte-level I2C write engine, with retry, timeout and status, before audio starts.

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16'd50000: idle cycles after reset or start before the first write.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd20000: maximum wait for i2c_done per transaction.
REQ-003 Parameter RETRY_MAX, default 2: retries per table entry after the first attempt.
REQ-004 Parameter AUTO_START, default 1: sequence starts by itself after reset deassertion.
REQ-005 clk25  in  1  single clock for all logic.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; (re)starts the sequence from entry 0.
REQ-008 i2c_req  out  1  transaction request to the I2C write engine.
REQ-009 i2c_data  out  24  {device byte 8'h34, reg[6:0], data[8], data[7:0]}.
REQ-010 i2c_done  in  1  one-cycle pulse: transaction finished.
REQ-011 i2c_nack  in  1  qualifies i2c_done; 1 = slave did not acknowledge.
REQ-012 busy  out  1  sequence in progress.
REQ-013 cfg_done  out  1  all entries written; audio datapath is released.
REQ-014 cfg_err  out  1  sequence aborted.
REQ-015 err_index  out  4  table index that failed; valid while cfg_err=1.

Function
REQ-016 A fixed table of 8 entries {reg,data9} is written in order: 0:(0x0F,0x000) reset, 1:(0x06,0x000) power, 2:(0x04,0x012) analog path, 3:(0x05,0x000) digital path, 4:(0x07,0x002) I2S 16-bit slave, 5:(0x02,0x079) left HP vol, 6:(0x03,0x079) right HP vol, 7:(0x09,0x001) activate.
REQ-017 The FSM has states IDLE, SETTLE, ISSUE, WAIT, NEXT, DONE, FAIL.
REQ-018 IDLE->SETTLE on start, or on the first cycle after reset when AUTO_START=1; index and retry counter are cleared.
REQ-019 SETTLE counts SETTLE_CYCLES cycles, then goes to ISSUE.
REQ-020 ISSUE asserts i2c_req with i2c_data built from the current index, then goes to WAIT on the next cycle.
REQ-021 i2c_req stays high through WAIT until the cycle i2c_done is sampled; it drops the following cycle.
REQ-022 i2c_data is stable whenever i2c_req=1.
REQ-023 WAIT, i2c_done=1, i2c_nack=0: go to NEXT and clear the retry counter.
REQ-024 WAIT, i2c_done=1, i2c_nack=1: failed attempt.
REQ-025 WAIT, TIMEOUT_CYCLES elapsed without i2c_done: failed attempt; the timeout counter restarts on each ISSUE.
REQ-026 Failed attempt with retry<RETRY_MAX: increment retry and go to ISSUE for the same index after one idle cycle with i2c_req=0.
REQ-027 Failed attempt otherwise: go to FAIL and latch err_index.
REQ-028 NEXT: if index=7 go to DONE, else increment index and go to ISSUE.
REQ-029 Index width is 3 bits internally; no wrap past 7.
REQ-030 DONE and FAIL are held until start.
REQ-031 start in any state (including WAIT with a request outstanding) restarts at SETTLE; i2c_req drops the same cycle.
REQ-032 A late i2c_done received after a restart or in IDLE/SETTLE/DONE/FAIL is ignored.
REQ-033 busy=1 in SETTLE, ISSUE, WAIT and NEXT.
REQ-034 cfg_done=1 only in DONE; cfg_err=1 only in FAIL.
REQ-035 All outputs are registered.

Reset
REQ-036 While rst_n=0, the FSM is in IDLE, all counters are 0, and i2c_req, busy, cfg_done, cfg_err, err_index and i2c_data are all 0, independent of clk25.
REQ-037 Reset asserted mid-transaction drops i2c_req immediately; with AUTO_START=1 the sequence restarts from entry 0 after deassertion.

Verification
REQ-038 Reset release, AUTO_START=1, engine acks every request after 10 cycles -> 8 requests carrying i2c_data 0x341E00, 0x340C00, 0x340812, 0x340A00, 0x340E02, 0x340479, 0x340679, 0x341201; then cfg_done=1, busy=0.
REQ-039 Entry 2 nacked twice then acked -> exactly 3 requests with 0x340812, then the sequence continues; cfg_err stays 0.
REQ-040 Entry 5 nacked 3 times -> FAIL, cfg_err=1, err_index=5, and no 4th request.
REQ-041 Engine never responds at entry 0 -> i2c_req held for TIMEOUT_CYCLES, 3 attempts total, then cfg_err=1 and err_index=0.
REQ-042 start pulsed while in WAIT at entry 4 -> i2c_req low the same cycle, SETTLE_CYCLES gap, next request 0x341E00; a stale i2c_done during SETTLE has no effect.
REQ-043 rst_n pulsed low for 3 cycles during WAIT -> all outputs 0 asynchronously, then the full sequence reruns to cfg_done=1.

Source files
------------

// File: rtl/codec_cfg_seq.sv
// Codec power-up sequencer: writes an 8-entry register table through a byte-level I2C write engine.
// States: IDLE rest | SETTLE power-up delay | ISSUE raise request | WAIT await engine | NEXT gap/advance | DONE ok | FAIL aborted
module codec_cfg_seq #(
    parameter logic [15:0] SETTLE_CYCLES  = 16'd50000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000,
    parameter int unsigned RETRY_MAX      = 2,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        start,
    output logic        i2c_req,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  err_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_FAIL
    } state_t;

    localparam logic [15:0] SETTLE_LOAD  = (SETTLE_CYCLES  == 16'd0) ? 16'd0 : SETTLE_CYCLES  - 16'd1;
    localparam logic [15:0] TIMEOUT_LOAD = (TIMEOUT_CYCLES == 16'd0) ? 16'd0 : TIMEOUT_CYCLES - 16'd1;
    localparam logic [7:0]  RETRY_LIM    = 8'(RETRY_MAX);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  retry_q, retry_d;
    logic        rpt_q, rpt_d;
    logic [3:0]  eidx_q, eidx_d;
    logic        req_q, busy_q, done_q, err_q;
    logic [23:0] data_q;
    logic        restart, attempt_fail;

    function automatic logic [23:0] entry_word(input logic [2:0] i);
        logic [6:0] r;
        logic [8:0] d;
        case (i)
            3'd0:    begin r = 7'h0F; d = 9'h000; end
            3'd1:    begin r = 7'h06; d = 9'h000; end
            3'd2:    begin r = 7'h04; d = 9'h012; end
            3'd3:    begin r = 7'h05; d = 9'h000; end
            3'd4:    begin r = 7'h07; d = 9'h002; end
            3'd5:    begin r = 7'h02; d = 9'h079; end
            3'd6:    begin r = 7'h03; d = 9'h079; end
            default: begin r = 7'h09; d = 9'h001; end
        endcase
        return {8'h34, r, d};
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        rpt_d        = rpt_q;
        eidx_d       = eidx_q;
        attempt_fail = 1'b0;
        restart      = start || (state_q == S_IDLE && AUTO_START);

        if (restart) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
            idx_d   = 3'd0;
            retry_d = 8'd0;
            rpt_d   = 1'b0;
            eidx_d  = 4'd0;
        end else begin
            unique case (state_q)
                S_SETTLE: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_ISSUE;
                        cnt_d   = TIMEOUT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                    if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                end
                S_WAIT: begin
                    // a response in the final timeout cycle still counts as a response
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            state_d = S_NEXT;
                            retry_d = 8'd0;
                            rpt_d   = 1'b0;
                        end else begin
                            attempt_fail = 1'b1;
                        end
                    end else if (cnt_q == 16'd0) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                    if (attempt_fail) begin
                        if (retry_q < RETRY_LIM) begin
                            retry_d = retry_q + 8'd1;
                            rpt_d   = 1'b1;
                            state_d = S_NEXT;
                        end else begin
                            state_d = S_FAIL;
                            eidx_d  = {1'b0, idx_q};
                        end
                    end
                end
                S_NEXT: begin
                    // NEXT doubles as the one idle cycle before a retry
                    if (rpt_q) begin
                        rpt_d   = 1'b0;
                        state_d = S_ISSUE;
                        cnt_d   = TIMEOUT_LOAD;
                    end else if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_ISSUE;
                        cnt_d   = TIMEOUT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            retry_q <= 8'd0;
            rpt_q   <= 1'b0;
            eidx_q  <= 4'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            rpt_q   <= rpt_d;
            eidx_q  <= eidx_d;
            req_q   <= (state_d == S_ISSUE) || (state_d == S_WAIT);
            busy_q  <= (state_d == S_SETTLE) || (state_d == S_ISSUE) ||
                       (state_d == S_WAIT)   || (state_d == S_NEXT);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_FAIL);
            if (state_d == S_ISSUE) data_q <= entry_word(idx_d);
        end
    end

    assign i2c_req   = req_q;
    assign i2c_data  = data_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = eidx_q;

endmodule
